// File: rtl/uart_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio_pkg
// Brief    : Register offsets, STATUS/CTRL bit indices and TX FSM encoding
// Revision : 1.0
// ============================================================================
package uart_mmio_pkg;

   localparam logic [7:0] REG_STATUS = 8'h00;
   localparam logic [7:0] REG_DATA   = 8'h04;
   localparam logic [7:0] REG_CTRL   = 8'h08;
   localparam logic [7:0] REG_IRQ_EN = 8'h0C;

   localparam int ST_TX_NOT_FULL  = 0;
   localparam int ST_RX_NOT_EMPTY = 1;
   localparam int ST_TX_EMPTY     = 2;
   localparam int ST_RX_OVERFLOW  = 3;
   localparam int ST_TX_OVERFLOW  = 4;
   localparam int ST_RX_COUNT_LSB = 8;
   localparam int ST_TX_COUNT_LSB = 16;

   localparam int CTRL_FLUSH_TX = 0;
   localparam int CTRL_FLUSH_RX = 1;
   localparam int CTRL_CLR_OVF  = 2;

   typedef enum logic [1:0] {
      TX_IDLE      = 2'd0,
      TX_WAIT_BUSY = 2'd1,
      TX_WAIT_DONE = 2'd2
   } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_mmio_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Power-of-2 synchronous FIFO with flush; head is shown on dout
// Revision : 1.0
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full  = (r_count == C_FULL);
   assign empty = (r_count == '0);
   assign count = r_count;
   assign dout  = r_mem[r_rd_ptr];

   // Decisions use the start-of-cycle count; flush overrides both ops.
   assign w_do_push = push & ~full  & ~flush;
   assign w_do_pop  = pop  & ~empty & ~flush;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/uart_mmio_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio_fifo
// Brief    : MMIO bridge to uart_tx/uart_rx with TX/RX FIFOs and TX launch FSM;
//            define UART_MMIO_IRQ_EN to add the IRQ_EN register and irq output
// Revision : 1.0
// ============================================================================
module uart_mmio_fifo
   import uart_mmio_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int BUS_WIDTH    = 32,
   parameter int DEPTH        = 16,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [7:0]            write_data,
   input  logic                  write_enable,
   input  logic                  read_enable,
   output logic [BUS_WIDTH-1:0]  read_data,
   input  logic [7:0]            rx_data,
   input  logic                  rx_data_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_data_valid,
   input  logic                  tx_busy
`ifdef UART_MMIO_IRQ_EN
   ,
   output logic                  irq
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   logic w_sel_status, w_sel_data, w_sel_ctrl;
   logic w_data_wr, w_data_rd, w_ctrl_wr;
   logic w_flush_tx, w_flush_rx, w_clr_ovf;

   assign w_sel_status = (addr == ADDR_WIDTH'(REG_STATUS));
   assign w_sel_data   = (addr == ADDR_WIDTH'(REG_DATA));
   assign w_sel_ctrl   = (addr == ADDR_WIDTH'(REG_CTRL));
   assign w_data_wr    = write_enable & w_sel_data;
   assign w_data_rd    = read_enable  & w_sel_data;
   assign w_ctrl_wr    = write_enable & w_sel_ctrl;
   assign w_flush_tx   = w_ctrl_wr & write_data[CTRL_FLUSH_TX];
   assign w_flush_rx   = w_ctrl_wr & write_data[CTRL_FLUSH_RX];
   assign w_clr_ovf    = w_ctrl_wr & write_data[CTRL_CLR_OVF];

   logic [7:0]    w_tx_head, w_rx_head;
   logic [CW-1:0] w_tx_count, w_rx_count;
   logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic          w_launch;

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_data_wr),
      .pop   (w_launch),
      .flush (w_flush_tx),
      .din   (write_data),
      .dout  (w_tx_head),
      .count (w_tx_count),
      .full  (w_tx_full),
      .empty (w_tx_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_data_valid),
      .pop   (w_data_rd & ~w_rx_empty),
      .flush (w_flush_rx),
      .din   (rx_data),
      .dout  (w_rx_head),
      .count (w_rx_count),
      .full  (w_rx_full),
      .empty (w_rx_empty)
   );

   logic r_rx_ovf, r_tx_ovf;

   always_ff @(posedge clk) begin
      if (reset || w_clr_ovf) begin
         r_rx_ovf <= 1'b0;
         r_tx_ovf <= 1'b0;
      end else begin
         if (rx_data_valid & w_rx_full) r_rx_ovf <= 1'b1;
         if (w_data_wr & w_tx_full)     r_tx_ovf <= 1'b1;
      end
   end

   tx_state_t     r_state, w_state_nxt;
   logic [TW-1:0] r_timer;

   // A launch is withheld while a TX flush is in progress so the popped
   // byte and the flush never race.
   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      unique case (r_state)
         TX_IDLE: begin
            if (!w_tx_empty && !tx_busy && !w_flush_tx) begin
               w_launch    = 1'b1;
               w_state_nxt = TX_WAIT_BUSY;
            end
         end
         TX_WAIT_BUSY: begin
            if (tx_busy)                                 w_state_nxt = TX_WAIT_DONE;
            else if (r_timer == TW'(BUSY_TIMEOUT - 1))   w_state_nxt = TX_IDLE;
         end
         TX_WAIT_DONE: begin
            if (!tx_busy) w_state_nxt = TX_IDLE;
         end
         default: w_state_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= TX_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_timer       <= '0;
         tx_data       <= '0;
         tx_data_valid <= 1'b0;
      end else begin
         tx_data_valid <= w_launch;
         if (w_launch) tx_data <= w_tx_head;
         if (r_state == TX_WAIT_BUSY && w_state_nxt == TX_WAIT_BUSY) r_timer <= r_timer + 1'b1;
         else                                                         r_timer <= '0;
      end
   end

`ifdef UART_MMIO_IRQ_EN
   logic       w_sel_irq;
   logic [2:0] r_irq_en;
   logic [2:0] w_irq_src;

   assign w_sel_irq = (addr == ADDR_WIDTH'(REG_IRQ_EN));
   assign w_irq_src = {r_rx_ovf | r_tx_ovf, w_tx_empty, ~w_rx_empty};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq_en <= '0;
         irq      <= 1'b0;
      end else begin
         if (write_enable && w_sel_irq) r_irq_en <= write_data[2:0];
         irq <= |(r_irq_en & w_irq_src);
      end
   end
`endif

   logic [BUS_WIDTH-1:0] w_status;

   always_comb begin
      w_status                              = '0;
      w_status[ST_TX_NOT_FULL]              = ~w_tx_full;
      w_status[ST_RX_NOT_EMPTY]             = ~w_rx_empty;
      w_status[ST_TX_EMPTY]                 = w_tx_empty;
      w_status[ST_RX_OVERFLOW]              = r_rx_ovf;
      w_status[ST_TX_OVERFLOW]              = r_tx_ovf;
      w_status[ST_RX_COUNT_LSB +: CW]       = w_rx_count;
      w_status[ST_TX_COUNT_LSB +: CW]       = w_tx_count;
   end

   always_comb begin
      read_data = '0;
      if (read_enable) begin
         if (w_sel_status)                  read_data = w_status;
         else if (w_sel_data && !w_rx_empty) read_data = BUS_WIDTH'(w_rx_head);
`ifdef UART_MMIO_IRQ_EN
         else if (w_sel_irq)                read_data = BUS_WIDTH'(r_irq_en);
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mmio_fifo
// Brief    : Directed + randomized bench for uart_mmio_fifo with a queue model
// Revision : 1.0
// ============================================================================
module tb_uart_mmio_fifo;
   localparam int DEPTH        = 16;
   localparam int BUSY_TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [7:0]  write_data;
   logic        write_enable, read_enable;
   logic [31:0] read_data;
   logic [7:0]  rx_data;
   logic        rx_data_valid;
   logic [7:0]  tx_data;
   logic        tx_data_valid;
   logic        tx_busy;
`ifdef UART_MMIO_IRQ_EN
   logic        irq;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          busy_cnt = 0;
   logic        force_busy = 1'b0;
   logic        tie0 = 1'b0;
   logic [7:0]  launched[$];
   int          launch_cyc[$];
   logic [7:0]  rx_q[$];
   bit          rx_ovf = 1'b0;
   bit          tx_ovf = 1'b0;

   uart_mmio_fifo #(
      .ADDR_WIDTH(32), .BUS_WIDTH(32), .DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
      .write_enable(write_enable), .read_enable(read_enable), .read_data(read_data),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid), .tx_data(tx_data),
      .tx_data_valid(tx_data_valid), .tx_busy(tx_busy)
`ifdef UART_MMIO_IRQ_EN
      , .irq(irq)
`endif
   );

   always #5 clk = ~clk;

   // uart_tx stand-in: busy for 20 cycles after each launch unless tied low
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_data_valid === 1'b1) begin
         launched.push_back(tx_data);
         launch_cyc.push_back(cyc);
         if (!tie0) busy_cnt <= 20;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end
   assign tx_busy = force_busy | (busy_cnt != 0);

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
      addr = a; write_data = d; write_enable = 1'b1;
      step();
      write_enable = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      addr = a; read_enable = 1'b1;
      #1 d = read_data;
      step();
      read_enable = 1'b0;
   endtask

   function automatic logic [31:0] exp_status(input int rxc, input int txc, input bit rxo, input bit txo);
      logic [31:0] s;
      s        = '0;
      s[23:16] = txc[7:0];
      s[15:8]  = rxc[7:0];
      s[4]     = txo;
      s[3]     = rxo;
      s[2]     = (txc == 0);
      s[1]     = (rxc != 0);
      s[0]     = (txc < DEPTH);
      return s;
   endfunction

   task automatic check_status(input string tag, input int txc);
      logic [31:0] d;
      bus_read(32'h0, d);
      check(tag, d, exp_status(rx_q.size(), txc, rx_ovf, tx_ovf));
   endtask

   // One RX-side bus cycle applied to both DUT and the queue model.
   task automatic rx_cycle(input bit push, input logic [7:0] b, input bit rd, input bit fl);
      bit was_full;
      rx_data = b; rx_data_valid = push;
      if (fl) begin
         addr = 32'h8; write_data = 8'h02; write_enable = 1'b1;
      end else if (rd) begin
         addr = 32'h4; read_enable = 1'b1;
      end
      #1;
      if (rd && !fl) check("rx_data_read", read_data, (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'h0);
      was_full = (rx_q.size() == DEPTH);
      if (fl) rx_q.delete();
      else begin
         if (rd && rx_q.size() > 0) void'(rx_q.pop_front());
         if (push) begin
            if (was_full) rx_ovf = 1'b1;
            else          rx_q.push_back(b);
         end
      end
      step();
      rx_data_valid = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
   endtask

   task automatic wait_launches(input int n, input int budget);
      int k = 0;
      while (launched.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      check("launch_count", launched.size(), n);
   endtask

   function automatic logic [7:0] launched_at(input int i);
      return (i < launched.size()) ? launched[i] : 8'hxx;
   endfunction

   initial begin
      logic [31:0] d;
      logic [7:0]  b0, b1;
      int          gap;

      reset = 1'b1; addr = '0; write_data = '0; write_enable = 1'b0;
      read_enable = 1'b0; rx_data = '0; rx_data_valid = 1'b0;
      repeat (3) step();
      reset = 1'b0;

      check("reset_tx_valid", tx_data_valid, 0);
      check("reset_tx_data", tx_data, 0);
      check_status("reset_status", 0);
      bus_read(32'h10, d); check("bad_addr_read", d, 0);
      bus_read(32'h08, d); check("ctrl_read", d, 0);
`ifndef UART_MMIO_IRQ_EN
      bus_write(32'h0C, 8'hFF);
      bus_read(32'h0C, d); check("irq_en_absent", d, 0);
`endif
      bus_write(32'h10, 8'hFF);
      check_status("bad_addr_write", 0);

      // three bytes queued while the UART is busy, then drained in order
      force_busy = 1'b1;
      bus_write(32'h4, 8'h41); bus_write(32'h4, 8'h42); bus_write(32'h4, 8'h43);
      check_status("t1_tx_count3", 3);
      launched.delete(); launch_cyc.delete();
      force_busy = 1'b0;
      wait_launches(3, 300);
      repeat (30) step();
      for (int i = 0; i < 3; i++) check("t1_byte", launched_at(i), 8'h41 + 8'(i));
      check("t1_pulses", launched.size(), 3);
      check_status("t1_drained", 0);

      // busy never rises: timeout, then the next byte launches
      tie0 = 1'b1; launched.delete(); launch_cyc.delete();
      b0 = 8'($urandom); b1 = 8'($urandom);
      bus_write(32'h4, b0); bus_write(32'h4, b1);
      wait_launches(2, 100);
      gap = (launch_cyc.size() >= 2) ? launch_cyc[1] - launch_cyc[0] : -1;
      check("t4_timeout_gap", gap, BUSY_TIMEOUT + 1);
      check("t4_byte0", launched_at(0), b0);
      check("t4_byte1", launched_at(1), b1);
      repeat (BUSY_TIMEOUT + 5) step();
      tie0 = 1'b0;
      check_status("t4_idle", 0);

      // TX full + overflow, then flush mid-frame
      force_busy = 1'b1; launched.delete();
      for (int i = 0; i < DEPTH; i++) bus_write(32'h4, 8'($urandom));
      bus_write(32'h4, 8'hEE); tx_ovf = 1'b1;
      check_status("t5_full_ovf", DEPTH);
      force_busy = 1'b0;
      wait_launches(1, 50);
      step();
      bus_write(32'h8, 8'h01);
      check_status("t5_flushed", 0);
      repeat (40) step();
      check("t5_no_more_launch", launched.size(), 1);
      check("t5_frame_done", tx_busy, 0);
      bus_write(32'h8, 8'h04); tx_ovf = 1'b0;
      check_status("t5_ovf_clear", 0);

      // RX overflow with CPU idle, then drain
      for (int i = 0; i < DEPTH + 1; i++) rx_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      check_status("t2_rx_full", 0);
      for (int i = 0; i < DEPTH + 1; i++) rx_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      bus_write(32'h8, 8'h04); rx_ovf = 1'b0;
      check_status("t2_ovf_clear", 0);

      // simultaneous push/pop at count 5 across pointer wrap
      repeat (5) rx_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 2 * DEPTH + 3; i++) rx_cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
      check_status("t3_count5", 0);

      // randomized RX traffic
      for (int i = 0; i < 150; i++) begin
         bit p, r, f;
         p = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 1) == 1);
         f = ($urandom_range(0, 24) == 0);
         if (f) begin p = 1'b0; r = 1'b0; end
         rx_cycle(p, 8'($urandom), r, f);
         if (i % 15 == 14) check_status("rand_status", 0);
      end
      rx_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      bus_write(32'h8, 8'h04); rx_ovf = 1'b0;
      check_status("rand_flush", 0);

`ifdef UART_MMIO_IRQ_EN
      bus_write(32'hC, 8'h01);
      bus_read(32'hC, d); check("t6_irq_en_rb", d, 1);
      rx_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      check("t6_irq_lat0", irq, 0);
      step();
      check("t6_irq_set", irq, 1);
      rx_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("t6_irq_hold", irq, 1);
      step();
      check("t6_irq_clr", irq, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
